leaf_stream_fifo: RTL and testbench
===================================

# leaf_stream_fifo

Synchronous valid/ready stream buffer used as a leaf stage under the five-way fan-out level of the generated test hierarchy. Each leaf instance accepts a data stream from its parent level, holds up to DEPTH words, and forwards them in order to the downstream consumer. It provides occupancy and almost-full status for parent-level flow control.

## Interface
- DATA_W, 8, width of each data word
- DEPTH, 8, storage entries; power of two, 2..256
- AFULL_LVL, 6, level at which `afull` asserts; 1..DEPTH
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous assert, active-low; deassertion is synchronised externally
- in_valid  input  1  upstream word present
- in_data  input  DATA_W  upstream word
- in_ready  output  1  space available; a transfer occurs when in_valid and in_ready are both high at a rising edge
- out_valid  output  1  downstream word present
- out_data  output  DATA_W  head-of-queue word
- out_ready  input  1  downstream accepts; a transfer occurs when out_valid and out_ready are both high at a rising edge
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- afull  output  1  high when level >= AFULL_LVL
- empty  output  1  high when level == 0

## Operation
- Storage is a DEPTH-entry register array with write pointer wp, read pointer rp, and occupancy count cnt. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH naturally.
- Push: fires on in_valid && in_ready. mem[wp] <= in_data and wp increments.
- Pop: fires on out_valid && out_ready. rp increments.
- cnt update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Derived outputs:
  - in_ready = (cnt != DEPTH)
  - out_valid = (cnt != 0)
  - out_data = mem[rp], a registered array read through a combinational mux
  - level = cnt
  - afull = (cnt >= AFULL_LVL)
  - empty = (cnt == 0)
- There is no combinational path from out_ready to in_ready. When full, a simultaneous pop does not allow a same-cycle push.
- When empty, an incoming word is not forwarded in the same cycle. It first appears on out_data one cycle after the push (no fall-through).
- Simultaneous push and pop at any 0 < cnt < DEPTH: both proceed and cnt is unchanged.
- in_data is ignored when in_ready is low. out_data is don't-care when out_valid is low, but must not be X after reset in simulation, so mem is not reset and out_data is gated to 0 when empty.
- Order is strictly FIFO. No word is dropped or duplicated.
- Reset mid-operation discards all contents. Pointers and cnt return to 0 immediately, regardless of clk.

## Timing
- Reset values:
  - in_ready = 1
  - out_valid = 0
  - out_data = 0
  - level = 0
  - afull = 0 (AFULL_LVL >= 1)
  - empty = 1
- Latency is 1 cycle from push edge to out_valid high (empty case).
- Throughput is one word per cycle in each direction, sustained.
- All status outputs change only after a rising clk edge or on rst_n assertion. There are no combinational input-to-output paths except the out_data mux from rp.

## Test plan
- Reset then idle: after rst_n rises, check in_ready=1, out_valid=0, level=0, empty=1, afull=0 for 5 cycles with no stimulus.
- Fill to full: hold out_ready=0 and push 0x01..0x08 on consecutive cycles.
  - afull rises after the 6th push (level=6).
  - in_ready falls after the 8th push.
  - A 9th word 0xFF held valid is not accepted.
  - level stays 8.
- Drain order: from full, set out_ready=1. Check out_data sequence 0x01..0x08 on 8 consecutive cycles, then out_valid=0 and empty=1.
- Streaming with simultaneous events: hold both valid and ready high and push 0x10..0x2F (32 words). Check output order matches, wrap-around of both pointers occurs 4 times, and level stays at 1 throughout after the first push.
- Full boundary: at level=8 with in_valid=1 and out_ready=1, pop 0x01. Check no push that cycle, level=7 next cycle, in_ready=1, and the word is accepted on the following edge.
- Reset mid-operation: at level=5, assert rst_n low between clock edges. Check level=0, out_valid=0, in_ready=1 immediately. After release, a push of 0xA5 emerges as the first word out.

Source files
------------

// File: rtl/leaf_stream_fifo.sv
// ---------------------------------------------------------------------------
// leaf_stream_fifo
//
// Valid/ready stream buffer for a leaf stage. It accepts words from the
// parent level, holds up to DEPTH of them, and forwards them in order to
// the downstream consumer. It also reports occupancy and almost-full so the
// parent level can throttle.
//
// Parameters
//   DATA_W    : width of each data word
//   DEPTH     : storage entries (power of two, 2..256)
//   AFULL_LVL : occupancy at which o_afull asserts (1..DEPTH)
//
// Ports
//   i_clk       : clock; all state updates on the rising edge
//   i_rst_n     : asynchronous active-low reset
//   i_in_valid  : upstream word present
//   i_in_data   : upstream word
//   o_in_ready  : space available (push on i_in_valid && o_in_ready)
//   o_out_valid : downstream word present
//   o_out_data  : head-of-queue word, forced to 0 while empty
//   i_out_ready : downstream accepts (pop on o_out_valid && i_out_ready)
//   o_level     : current occupancy, 0..DEPTH
//   o_afull     : o_level >= AFULL_LVL
//   o_empty     : o_level == 0
// ---------------------------------------------------------------------------
module leaf_stream_fifo #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AFULL_LVL = 6
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_in_valid,
  input  logic [DATA_W-1:0]        i_in_data,
  output logic                     o_in_ready,
  output logic                     o_out_valid,
  output logic [DATA_W-1:0]        o_out_data,
  input  logic                     i_out_ready,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_afull,
  output logic                     o_empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [CntW-1:0] CntFull  = CntW'(DEPTH);
  localparam logic [CntW-1:0] CntAfull = CntW'(AFULL_LVL);

  // Storage and bookkeeping state
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]   r_wp;
  logic [PtrW-1:0]   r_rp;
  logic [CntW-1:0]   r_cnt;

  logic [PtrW-1:0]   w_wp_d;
  logic [PtrW-1:0]   w_rp_d;
  logic [CntW-1:0]   w_cnt_d;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;

  // Status is derived purely from the registered count, so ready never
  // depends combinationally on i_out_ready: a pop while full cannot open
  // room for a same-cycle push.
  assign w_full  = (r_cnt == CntFull);
  assign w_empty = (r_cnt == '0);

  assign w_push  = i_in_valid && !w_full;
  assign w_pop   = !w_empty && i_out_ready;

  // Next-state for pointers and occupancy. Pointers are exactly PtrW bits,
  // so incrementing past DEPTH-1 wraps to 0 with no extra logic.
  always_comb begin
    w_wp_d  = r_wp;
    w_rp_d  = r_rp;
    w_cnt_d = r_cnt;

    if (w_push) begin
      w_wp_d = r_wp + PtrW'(1);
    end
    if (w_pop) begin
      w_rp_d = r_rp + PtrW'(1);
    end

    unique case ({w_push, w_pop})
      2'b10:   w_cnt_d = r_cnt + CntW'(1);
      2'b01:   w_cnt_d = r_cnt - CntW'(1);
      default: w_cnt_d = r_cnt;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      r_wp  <= w_wp_d;
      r_rp  <= w_rp_d;
      r_cnt <= w_cnt_d;
    end
  end

  // The array is deliberately not reset; stale contents are unreachable
  // because the read side is gated by the count.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wp] <= i_in_data;
    end
  end

  // Outputs. The only combinational read path is the mux from r_rp; a word
  // pushed into an empty buffer appears here one cycle later.
  assign o_in_ready  = !w_full;
  assign o_out_valid = !w_empty;
  assign o_out_data  = w_empty ? '0 : r_mem[r_rp];
  assign o_level     = r_cnt;
  assign o_afull     = (r_cnt >= CntAfull);
  assign o_empty     = w_empty;

endmodule

// File: tb/tb_leaf_stream_fifo.sv
// ---------------------------------------------------------------------------
// tb_leaf_stream_fifo
//
// Self-checking bench for leaf_stream_fifo. A queue-based reference model
// tracks the expected contents; status and head word are derived from the
// queue size and front element.
// ---------------------------------------------------------------------------
module tb_leaf_stream_fifo;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned DEPTH     = 8;
  localparam int unsigned AFULL_LVL = 6;
  localparam int unsigned LvlW      = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic [LvlW-1:0]   level;
  logic              afull;
  logic              empty;

  int n_checks;
  int n_pass;

  // Reference model: words currently held, head at index 0.
  logic [DATA_W-1:0] q[$];

  leaf_stream_fifo #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .AFULL_LVL(AFULL_LVL)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_in_valid (in_valid),
    .i_in_data  (in_data),
    .o_in_ready (in_ready),
    .o_out_valid(out_valid),
    .o_out_data (out_data),
    .i_out_ready(out_ready),
    .o_level    (level),
    .o_afull    (afull),
    .o_empty    (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {in_ready, out_valid, level, afull, empty, out_data}
  logic [15:0] got_status;
  assign got_status = {in_ready, out_valid, level, afull, empty, out_data};

  function automatic logic [15:0] model_status();
    int n;
    logic [DATA_W-1:0] head;
    n    = q.size();
    head = (n != 0) ? q[0] : '0;
    return {(n != DEPTH), (n != 0), 4'(n), (n >= AFULL_LVL), (n == 0), head};
  endfunction

  // Drive one cycle: inputs applied now, model advanced by what the
  // specification says fires at the next rising edge, sampled 1 after it.
  task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic r);
    bit do_push;
    bit do_pop;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    do_push   = v && (q.size() < DEPTH);
    do_pop    = r && (q.size() > 0);
    @(posedge clk);
    if (do_pop)  void'(q.pop_front());
    if (do_push) q.push_back(d);
    #1;
  endtask

  task automatic test_reset();
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    q.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0, 1'b0);
      n_checks++;
      if (got_status !== 16'h8100)
        $display("FAIL reset_idle cyc%0d: got %h want %h", i, got_status, 16'h8100);
      else n_pass++;
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 8'(i), 1'b0);
      n_checks++;
      if (got_status !== model_status())
        $display("FAIL fill_status push%0d: got %h want %h", i, got_status, model_status());
      else n_pass++;
      if (i == 5 || i == 6) begin
        n_checks++;
        if (afull !== (i == 6))
          $display("FAIL fill_afull push%0d: got %b want %b", i, afull, (i == 6));
        else n_pass++;
      end
    end
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL fill_in_ready: got %b want 0", in_ready);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 8'hFF, 1'b0);
      n_checks++;
      if (level !== 4'd8 || got_status !== model_status())
        $display("FAIL fill_overflow cyc%0d: got %h want %h", i, got_status, model_status());
      else n_pass++;
    end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 8; i++) begin
      n_checks++;
      if (out_data !== 8'(i) || out_valid !== 1'b1)
        $display("FAIL drain_data pop%0d: got %h/%b want %h/1", i, out_data, out_valid, 8'(i));
      else n_pass++;
      step(1'b0, '0, 1'b1);
    end
    n_checks++;
    if (out_valid !== 1'b0 || empty !== 1'b1 || got_status !== model_status())
      $display("FAIL drain_empty: got %h want %h", got_status, model_status());
    else n_pass++;
  endtask

  task automatic test_stream();
    for (int i = 0; i < 32; i++) begin
      if (i > 0) begin
        n_checks++;
        if (out_data !== 8'(8'h10 + i - 1))
          $display("FAIL stream_data w%0d: got %h want %h", i, out_data, 8'(8'h10 + i - 1));
        else n_pass++;
      end
      step(1'b1, 8'(8'h10 + i), 1'b1);
      n_checks++;
      if (level !== 4'd1 || got_status !== model_status())
        $display("FAIL stream_level w%0d: got %h want %h", i, got_status, model_status());
      else n_pass++;
    end
    step(1'b0, '0, 1'b1);
    n_checks++;
    if (got_status !== 16'h8100)
      $display("FAIL stream_tail: got %h want %h", got_status, 16'h8100);
    else n_pass++;
  endtask

  task automatic test_full_boundary();
    for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0);
    n_checks++;
    if (out_data !== 8'h01 || level !== 4'd8)
      $display("FAIL fb_head: got %h/%0d want 01/8", out_data, level);
    else n_pass++;
    step(1'b1, 8'h99, 1'b1);
    n_checks++;
    if (level !== 4'd7 || in_ready !== 1'b1 || got_status !== model_status())
      $display("FAIL fb_pop_only: got %h want %h", got_status, model_status());
    else n_pass++;
    step(1'b1, 8'h99, 1'b0);
    n_checks++;
    if (level !== 4'd8 || got_status !== model_status())
      $display("FAIL fb_accept: got %h want %h", got_status, model_status());
    else n_pass++;
    while (q.size() != 0) begin
      n_checks++;
      if (got_status !== model_status())
        $display("FAIL fb_drain: got %h want %h", got_status, model_status());
      else n_pass++;
      step(1'b0, '0, 1'b1);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0);
    n_checks++;
    if (level !== 4'd5) $display("FAIL rm_pre_level: got %0d want 5", level);
    else n_pass++;
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    q.delete();
    #1;
    n_checks++;
    if (level !== 4'd0 || out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL rm_async: got lvl=%0d ov=%b ir=%b want 0/0/1", level, out_valid, in_ready);
    else n_pass++;
    @(posedge clk);
    #3 rst_n = 1'b1;
    step(1'b1, 8'hA5, 1'b0);
    n_checks++;
    if (out_data !== 8'hA5 || out_valid !== 1'b1 || level !== 4'd1)
      $display("FAIL rm_first_word: got %h/%b/%0d want a5/1/1", out_data, out_valid, level);
    else n_pass++;
    step(1'b0, '0, 1'b1);
  endtask

  task automatic test_random();
    int pv;
    int pr;
    for (int blk = 0; blk < 4; blk++) begin
      pv = 20 + 25 * blk;
      pr = 95 - 25 * blk;
      for (int i = 0; i < 100; i++) begin
        step(($urandom_range(99) < pv), 8'($urandom), ($urandom_range(99) < pr));
        n_checks++;
        if (got_status !== model_status())
          $display("FAIL random b%0d c%0d: got %h want %h", blk, i, got_status, model_status());
        else n_pass++;
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_full_boundary();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
